// File: rtl/gate_sweep_engine.sv
// N-input gate evaluator that sweeps its input vector through every value and records a truth table.
// Optional self-check against a supplied table is enabled by defining TT_CHECK_EN.
module gate_sweep_engine #(
  parameter int unsigned N_IN        = 2,
  parameter int unsigned STEP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [2:0]           op,
`ifdef TT_CHECK_EN
  input  logic [2**N_IN-1:0]   expected,
  output logic                 mismatch,
  output logic [N_IN-1:0]      first_bad,
`endif
  output logic [N_IN-1:0]      vec,
  output logic                 y,
  output logic                 vec_valid,
  output logic                 busy,
  output logic                 done,
  output logic [2**N_IN-1:0]   tt
);

  localparam int          TtW      = 2**N_IN;
  localparam int unsigned HoldW    = $clog2(STEP_CYCLES) + 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(STEP_CYCLES - 1);
  localparam logic [N_IN-1:0]  VecLast  = '1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [TtW-1:0]   tt_q, tt_d;
  logic [2:0]       op_q, op_d;
  logic             y_raw;
  logic             accept;

  function automatic logic gate_eval(input logic [2:0] f, input logic [N_IN-1:0] v);
    logic r;
    case (f)
      3'd0:    r = &v;
      3'd1:    r = |v;
      3'd2:    r = ~&v;
      3'd3:    r = ~|v;
      3'd4:    r = ^v;
      3'd5:    r = ~^v;
      3'd6:    r = v[0];
      default: r = ~v[0];
    endcase
    return r;
  endfunction

  assign y_raw  = gate_eval(op_q, vec_q);
  assign accept = (state_q == StIdle) && start;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    hold_d  = hold_q;
    tt_d    = tt_q;
    op_d    = op_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          op_d    = op;
          vec_d   = '0;
          tt_d    = '0;
          hold_d  = '0;
        end
      end
      StRun: begin
        if (hold_q == HoldLast) begin
          tt_d[vec_q] = y_raw;
          hold_d      = '0;
          if (vec_q == VecLast) begin
            state_d = StDone;
            vec_d   = '0;
          end else begin
            vec_d = vec_q + 1'b1;
          end
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= '0;
      hold_q  <= '0;
      tt_q    <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      hold_q  <= hold_d;
      tt_q    <= tt_d;
      op_q    <= op_d;
    end
  end

  assign vec       = vec_q;
  assign vec_valid = (state_q == StRun);
  assign busy      = (state_q == StRun);
  assign done      = (state_q == StDone);
  assign y         = vec_valid ? y_raw : 1'b0;
  assign tt        = tt_q;

`ifdef TT_CHECK_EN
  logic [TtW-1:0]  expected_q, expected_d;
  logic            mismatch_q, mismatch_d;
  logic [N_IN-1:0] first_bad_q, first_bad_d;

  // Scan from the top so the lowest differing index is the one left standing.
  always_comb begin
    expected_d  = expected_q;
    mismatch_d  = mismatch_q;
    first_bad_d = first_bad_q;
    if (accept) begin
      expected_d  = expected;
      mismatch_d  = 1'b0;
      first_bad_d = '0;
    end else if (state_q == StDone) begin
      mismatch_d  = (tt_q != expected_q);
      first_bad_d = '0;
      for (int i = TtW - 1; i >= 0; i--) begin
        if (tt_q[i] != expected_q[i]) begin
          first_bad_d = N_IN'(i);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expected_q  <= '0;
      mismatch_q  <= 1'b0;
      first_bad_q <= '0;
    end else begin
      expected_q  <= expected_d;
      mismatch_q  <= mismatch_d;
      first_bad_q <= first_bad_d;
    end
  end

  assign mismatch  = mismatch_q;
  assign first_bad = first_bad_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

`ifndef SYNTHESIS
  done_one_cycle_a: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StDone) |=> (state_q == StIdle));
  hold_in_range_a: assert property (@(posedge clk) disable iff (!rst_n)
    hold_q <= HoldLast);
`endif

endmodule

// File: tb/tb_gate_sweep_engine.sv
// Randomized bench for gate_sweep_engine: three configurations run in lockstep against a
// cycle-indexed reference model. Define TT_CHECK_EN to also exercise the self-check ports.
module tb_gate_sweep_engine;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;

  logic [1:0] vec_a; logic y_a, vv_a, busy_a, done_a; logic [3:0] tt_a;
  logic [2:0] vec_b; logic y_b, vv_b, busy_b, done_b; logic [7:0] tt_b;
  logic [1:0] vec_c; logic y_c, vv_c, busy_c, done_c; logic [3:0] tt_c;

`ifdef TT_CHECK_EN
  logic [3:0] exp_a, exp_c;
  logic [7:0] exp_b;
  logic       mm_a, mm_b, mm_c;
  logic [1:0] fb_a, fb_c;
  logic [2:0] fb_b;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gate_sweep_engine #(.N_IN(2), .STEP_CYCLES(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
`ifdef TT_CHECK_EN
    .expected(exp_a), .mismatch(mm_a), .first_bad(fb_a),
`endif
    .vec(vec_a), .y(y_a), .vec_valid(vv_a), .busy(busy_a), .done(done_a), .tt(tt_a)
  );

  gate_sweep_engine #(.N_IN(3), .STEP_CYCLES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
`ifdef TT_CHECK_EN
    .expected(exp_b), .mismatch(mm_b), .first_bad(fb_b),
`endif
    .vec(vec_b), .y(y_b), .vec_valid(vv_b), .busy(busy_b), .done(done_b), .tt(tt_b)
  );

  gate_sweep_engine #(.N_IN(2), .STEP_CYCLES(10)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
`ifdef TT_CHECK_EN
    .expected(exp_c), .mismatch(mm_c), .first_bad(fb_c),
`endif
    .vec(vec_c), .y(y_c), .vec_valid(vv_c), .busy(busy_c), .done(done_c), .tt(tt_c)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  function automatic logic ref_gate(input logic [2:0] o, input int v, input int n);
    int ones = 0;
    for (int b = 0; b < n; b++) ones += (v >> b) & 1;
    case (o)
      3'd0:    return ones == n;
      3'd1:    return ones > 0;
      3'd2:    return ones != n;
      3'd3:    return ones == 0;
      3'd4:    return (ones % 2) == 1;
      3'd5:    return (ones % 2) == 0;
      3'd6:    return (v % 2) == 1;
      default: return (v % 2) == 0;
    endcase
  endfunction

  // Truth table with only the first `count` vectors captured.
  function automatic logic [63:0] ref_tt(input logic [2:0] o, input int n, input int count);
    logic [63:0] r = '0;
    for (int i = 0; i < count; i++) r[i] = ref_gate(o, i, n);
    return r;
  endfunction

  // j = clock edges since the edge that accepted start.
  task automatic check_unit(input string u, input int n, input int s, input int j,
                            input logic [2:0] o, input logic [63:0] vec_o, input logic y_o,
                            input logic vv_o, input logic busy_o, input logic done_o,
                            input logic [63:0] tt_o);
    int   total = (1 << n) * s;
    logic run   = (j < total);
    int   v     = run ? j / s : 0;
    int   cnt   = run ? j / s : (1 << n);
    check({u, ".busy"}, 64'(busy_o), 64'(run));
    check({u, ".vec_valid"}, 64'(vv_o), 64'(run));
    check({u, ".done"}, 64'(done_o), 64'(j == total));
    check({u, ".vec"}, vec_o, 64'(v));
    check({u, ".y"}, 64'(y_o), 64'(run ? ref_gate(o, v, n) : 1'b0));
    check({u, ".tt"}, tt_o, ref_tt(o, n, cnt));
  endtask

`ifdef TT_CHECK_EN
  task automatic check_self(input string u, input int n, input int s, input int j,
                            input logic [2:0] o, input logic [63:0] ex,
                            input logic mm_o, input logic [63:0] fb_o);
    int          total = (1 << n) * s;
    logic [63:0] t     = ref_tt(o, n, 1 << n);
    logic        bad   = 1'b0;
    int          first = 0;
    for (int i = 0; i < (1 << n); i++) begin
      if (!bad && t[i] != ex[i]) begin
        bad   = 1'b1;
        first = i;
      end
    end
    if (j <= total) begin
      bad   = 1'b0;
      first = 0;
    end
    check({u, ".mismatch"}, 64'(mm_o), 64'(bad));
    check({u, ".first_bad"}, fb_o, 64'(first));
  endtask

  task automatic set_exps(input logic [2:0] o);
    logic [63:0] t;
    t = ref_tt(o, 2, 4);
    exp_a = ($urandom_range(0, 1) == 1) ? t[3:0] : 4'($urandom);
    exp_c = ($urandom_range(0, 1) == 1) ? t[3:0] : 4'($urandom);
    t = ref_tt(o, 3, 8);
    exp_b = ($urandom_range(0, 1) == 1) ? t[7:0] : 8'($urandom);
  endtask
`endif

  task automatic check_all_zero(input string tag);
    check({tag, ".a"}, {busy_a, vv_a, done_a, y_a, 2'b0, vec_a, tt_a}, 64'd0);
    check({tag, ".b"}, {busy_b, vv_b, done_b, y_b, 1'b0, vec_b, tt_b}, 64'd0);
    check({tag, ".c"}, {busy_c, vv_c, done_c, y_c, 2'b0, vec_c, tt_c}, 64'd0);
`ifdef TT_CHECK_EN
    check({tag, ".chk"}, {mm_a, mm_b, mm_c, fb_a, fb_b, fb_c}, 64'd0);
`endif
  endtask

  // Runs one sweep from an idle state; abort_at >= 0 pulls reset mid-sweep at that cycle.
  task automatic run_sweep(input logic [2:0] o, input bit disturb, input int abort_at);
    logic [2:0] lop;
`ifdef TT_CHECK_EN
    logic [3:0] la, lc;
    logic [7:0] lb;
    la = exp_a; lb = exp_b; lc = exp_c;
`endif
    lop   = o;
    op    = o;
    start = 1'b1;
    for (int j = 0; j <= 41; j++) begin
      @(posedge clk); #1;
      start = 1'b0;
      check_unit("a", 2, 1, j, lop, 64'(vec_a), y_a, vv_a, busy_a, done_a, 64'(tt_a));
      check_unit("b", 3, 1, j, lop, 64'(vec_b), y_b, vv_b, busy_b, done_b, 64'(tt_b));
      check_unit("c", 2, 10, j, lop, 64'(vec_c), y_c, vv_c, busy_c, done_c, 64'(tt_c));
`ifdef TT_CHECK_EN
      check_self("a", 2, 1, j, lop, 64'(la), mm_a, 64'(fb_a));
      check_self("b", 3, 1, j, lop, 64'(lb), mm_b, 64'(fb_b));
      check_self("c", 2, 10, j, lop, 64'(lc), mm_c, 64'(fb_c));
`endif
      if (j == abort_at) begin
        #1 rst_n = 1'b0;
        #1 check_all_zero("async_reset");
        #1 rst_n = 1'b1;
        return;
      end
      // Every unit is in RUN or DONE here, so any start must be ignored.
      if (disturb && j <= 4) begin
        start = (j == 4) ? 1'b1 : 1'($urandom_range(0, 1));
        op    = 3'($urandom);
`ifdef TT_CHECK_EN
        exp_a = 4'($urandom); exp_b = 8'($urandom); exp_c = 4'($urandom);
`endif
      end else if (disturb) begin
        op = 3'($urandom);
      end
    end
    start = 1'b0;
  endtask

  initial begin
    logic [2:0] o;
    rst_n = 1'b0;
    start = 1'b0;
    op    = 3'd0;
`ifdef TT_CHECK_EN
    exp_a = '0; exp_b = '0; exp_c = '0;
`endif
    start = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_all_zero("reset_hold");
    start = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check_all_zero("idle_after_reset");

`ifdef TT_CHECK_EN
    exp_a = 4'b0001; exp_b = 8'h01; exp_c = 4'b0001;
`endif
    run_sweep(3'd3, 1'b0, -1);
    check("nor_tt_a", 64'(tt_a), 64'(4'b0001));
    check("nor_tt_c", 64'(tt_c), 64'(4'b0001));
`ifdef TT_CHECK_EN
    check("nor_match_a", 64'(mm_a), 64'd0);
    exp_a = 4'b0011;
    run_sweep(3'd3, 1'b0, -1);
    check("nor_bad_mm_a", 64'(mm_a), 64'd1);
    check("nor_bad_fb_a", 64'(fb_a), 64'd1);
`endif

    run_sweep(3'd2, 1'b0, -1);
    check("nand_tt_a", 64'(tt_a), 64'(4'b0111));
    run_sweep(3'd0, 1'b0, -1);
    check("and_tt_c", 64'(tt_c), 64'(4'b1000));
    run_sweep(3'd4, 1'b0, -1);
    check("xor_tt_b", 64'(tt_b), 64'(8'b1001_0110));
    run_sweep(3'd5, 1'b0, -1);
    check("xnor_tt_b", 64'(tt_b), 64'(8'b0110_1001));

    // Restarts, op changes and a start during DONE must all be ignored.
    run_sweep(3'd1, 1'b1, -1);

    for (int r = 0; r < 10; r++) begin
      o = 3'($urandom);
`ifdef TT_CHECK_EN
      set_exps(o);
`endif
      run_sweep(o, 1'($urandom_range(0, 1)), -1);
    end

    run_sweep(3'd6, 1'b0, 2);
    run_sweep(3'd7, 1'b0, -1);
    check("post_reset_tt_b", 64'(tt_b), 64'(8'b0101_0101));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
